ddr3_cmd_seq: RTL

DDR3_CMD_SEQ -- requirements
Module: ddr3_cmd_seq

---
 rtl/ddr3_cmd_seq.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/ddr3_cmd_seq.sv
// ddr3_cmd_seq: single-request DDR3 command sequencer with per-bank open-row tracking and periodic refresh
module ddr3_cmd_seq #(
    parameter int NUM_BANKS = 8,
    parameter int ROW_W     = 15,
    parameter int COL_W     = 10,
    parameter int T_RCD     = 5,
    parameter int T_RP      = 5,
    parameter int T_RFC     = 10,
    parameter int T_REFI    = 780,
    localparam int BA_W     = $clog2(NUM_BANKS)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             init_done_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_write_i,
    input  logic             req_ap_i,
    input  logic [BA_W-1:0]  req_bank_i,
    input  logic [ROW_W-1:0] req_row_i,
    input  logic [COL_W-1:0] req_col_i,
    output logic             cs_o,
    output logic             ras_o,
    output logic             cas_o,
    output logic             we_o,
    output logic [ROW_W-1:0] addr_o,
    output logic [BA_W-1:0]  ba_o,
    output logic             cmd_done_o,
    output logic             ref_late_o
);
    localparam int T_MAX = (T_RCD > T_RP) ? ((T_RCD > T_RFC) ? T_RCD : T_RFC) : ((T_RP > T_RFC) ? T_RP : T_RFC);
    localparam int CW    = $clog2(T_MAX + 1);
    localparam int RCW   = $clog2(T_REFI);
    localparam logic [3:0] C_DES = 4'b1111, C_NOP = 4'b0111, C_ACT = 4'b0011, C_RD = 4'b0101,
                           C_WR  = 4'b0100, C_PRE = 4'b0010, C_REF = 4'b0001;

    typedef enum logic [3:0] {
        S_IDLE, S_PRE, S_PRE_WAIT, S_ACT, S_ACT_WAIT, S_RW, S_PREA, S_PREA_WAIT, S_REF, S_REF_WAIT
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [RCW-1:0]     rcnt_q, rcnt_d;
    logic               pend_q, pend_d, apw_q, apw_d;
    logic [NUM_BANKS-1:0] open_q, open_d;
    logic [ROW_W-1:0]   tab_row_q [NUM_BANKS];
    logic               wr_q, wr_d, ap_q, ap_d;
    logic [BA_W-1:0]    bank_q, bank_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [3:0]         cmd_q, cmd_d;
    logic [ROW_W-1:0]   addr_q, addr_d;
    logic [BA_W-1:0]    ba_q, ba_d;
    logic               ready_q, ready_d, done_q, done_d, late_q, late_d;
    logic               accept, hit, wrap;

    assign accept = req_valid_i & ready_q;
    assign hit    = open_q[req_bank_i] && (tab_row_q[req_bank_i] == req_row_i);
    assign wrap   = init_done_i && (rcnt_q == RCW'(T_REFI - 1));

    // State register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next-state: refresh takes priority in IDLE; an accepted request always runs to completion
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:      if (init_done_i && pend_q) state_d = (|open_q) ? S_PREA : S_REF;
                         else if (accept)           state_d = hit ? S_RW : (open_q[req_bank_i] ? S_PRE : S_ACT);
            S_PRE:       state_d = S_PRE_WAIT;
            S_PRE_WAIT:  if (cnt_q == '0) state_d = apw_q ? S_IDLE : S_ACT;
            S_ACT:       state_d = S_ACT_WAIT;
            S_ACT_WAIT:  if (cnt_q == '0) state_d = S_RW;
            S_RW:        state_d = ap_q ? S_PRE_WAIT : S_IDLE;
            S_PREA:      state_d = S_PREA_WAIT;
            S_PREA_WAIT: if (cnt_q == '0) state_d = S_REF;
            S_REF:       state_d = S_REF_WAIT;
            S_REF_WAIT:  if (cnt_q == '0) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Datapath next values: wait counter, refresh timer, bank table and latched request
    always_comb begin
        unique case (state_q)
            S_PRE, S_PREA:                          cnt_d = CW'(T_RP - 2);
            S_ACT:                                  cnt_d = CW'(T_RCD - 2);
            S_REF:                                  cnt_d = CW'(T_RFC - 1);
            S_RW:                                   cnt_d = CW'(T_RP - 1);
            S_PRE_WAIT, S_ACT_WAIT, S_PREA_WAIT, S_REF_WAIT: cnt_d = cnt_q - 1'b1;
            default:                                cnt_d = '0;
        endcase
        apw_d  = (state_q == S_RW) ? ap_q : (apw_q & (state_q != S_IDLE));
        rcnt_d = init_done_i ? (wrap ? '0 : rcnt_q + 1'b1) : rcnt_q;
        pend_d = wrap | (pend_q & (state_d != S_REF));
        open_d = open_q;
        if (state_q == S_ACT) open_d[bank_q] = 1'b1;
        if (state_q == S_PRE || (state_q == S_RW && ap_q)) open_d[bank_q] = 1'b0;
        if (state_q == S_PREA) open_d = '0;
        wr_d   = (state_q == S_IDLE && accept) ? req_write_i : wr_q;
        ap_d   = (state_q == S_IDLE && accept) ? req_ap_i    : ap_q;
        bank_d = (state_q == S_IDLE && accept) ? req_bank_i  : bank_q;
        row_d  = (state_q == S_IDLE && accept) ? req_row_i   : row_q;
        col_d  = (state_q == S_IDLE && accept) ? req_col_i   : col_q;
    end

    // Datapath registers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q  <= '0;
            rcnt_q <= '0;
            pend_q <= 1'b0;
            apw_q  <= 1'b0;
            open_q <= '0;
            wr_q   <= 1'b0;
            ap_q   <= 1'b0;
            bank_q <= '0;
            row_q  <= '0;
            col_q  <= '0;
            for (int i = 0; i < NUM_BANKS; i++) tab_row_q[i] <= '0;
        end else begin
            cnt_q  <= cnt_d;
            rcnt_q <= rcnt_d;
            pend_q <= pend_d;
            apw_q  <= apw_d;
            open_q <= open_d;
            wr_q   <= wr_d;
            ap_q   <= ap_d;
            bank_q <= bank_d;
            row_q  <= row_d;
            col_q  <= col_d;
            if (state_q == S_ACT) tab_row_q[bank_q] <= row_q;
        end
    end

    // Outputs decoded from the state being entered so pins register cleanly alongside the state
    always_comb begin
        cmd_d  = init_done_i ? C_NOP : C_DES;
        addr_d = '0;
        ba_d   = '0;
        unique case (state_d)
            S_PRE:  begin cmd_d = C_PRE; ba_d = bank_d; end
            S_ACT:  begin cmd_d = C_ACT; ba_d = bank_d; addr_d = row_d; end
            S_RW:   begin cmd_d = wr_d ? C_WR : C_RD; ba_d = bank_d; addr_d[COL_W-1:0] = col_d; addr_d[10] = ap_d; end
            S_PREA: begin cmd_d = C_PRE; addr_d[10] = 1'b1; end
            S_REF:  cmd_d = C_REF;
            default: ;
        endcase
        ready_d = (state_d == S_IDLE) && init_done_i && !pend_d;
        done_d  = (state_d == S_RW);
        late_d  = wrap & pend_q & (state_d != S_REF);
    end

    // Output registers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cmd_q   <= C_DES;
            addr_q  <= '0;
            ba_q    <= '0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            late_q  <= 1'b0;
        end else begin
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            ba_q    <= ba_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            late_q  <= late_d;
        end
    end

    assign {cs_o, ras_o, cas_o, we_o} = cmd_q;
    assign addr_o      = addr_q;
    assign ba_o        = ba_q;
    assign req_ready_o = ready_q;
    assign cmd_done_o  = done_q;
    assign ref_late_o  = late_q;
endmodule
